// File: rtl/dnn_mac_sched.sv
// dnn_mac_sched: control sequencer time-sharing one MAC unit over a 4-4-2 DNN.
// Optional macro DNN_SCHED_STALL_EN adds the mac_stall input that freezes issue and write-back.
module dnn_mac_sched #(
   parameter int MAC_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_ready,
`ifdef DNN_SCHED_STALL_EN
   input  logic       mac_stall,
`endif
   output logic       in_ack,
   output logic       busy,
   output logic       overrun,
   output logic       mac_en,
   output logic       mac_clr,
   output logic       layer,
   output logic [1:0] nrn_idx,
   output logic [1:0] src_idx,
   output logic       hid_wr,
   output logic       out_wr,
   output logic [1:0] wr_idx,
   output logic       out0_ready,
   output logic       out1_ready
);
   typedef enum logic [2:0] {IDLE, L1, WAIT1, L2, WAIT2} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MAC_LAT - 1);

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       stall;
   // Write-back delay line entries are {valid, layer, neuron index}.
   logic [3:0] dly_reg [MAC_LAT];
   logic [3:0] dly_next;
   logic [3:0] dly_tail;

`ifdef DNN_SCHED_STALL_EN
   assign stall = mac_stall;
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAC_LAT; i++) dly_reg[i] <= '0;
      end else if (!stall) begin
         dly_reg[0] <= dly_next;
         for (int i = 1; i < MAC_LAT; i++) dly_reg[i] <= dly_reg[i-1];
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      in_ack     = 1'b0;
      mac_en     = 1'b0;
      mac_clr    = 1'b0;
      layer      = 1'b0;
      nrn_idx    = 2'd0;
      src_idx    = 2'd0;
      case (state_reg)
         IDLE: begin
            // Acceptance is not blocked by a stall; only issue waits.
            if (in_ready && !rst) begin
               in_ack     = 1'b1;
               state_next = L1;
               cnt_next   = '0;
            end
         end
         L1: begin
            if (!stall) begin
               mac_en   = 1'b1;
               nrn_idx  = cnt_reg[3:2];
               src_idx  = cnt_reg[1:0];
               mac_clr  = (cnt_reg[1:0] == 2'd0);
               cnt_next = cnt_reg + 4'd1;
               if (cnt_reg == 4'd15) begin
                  state_next = WAIT1;
                  cnt_next   = '0;
               end
            end
         end
         WAIT1: begin
            if (!stall) begin
               cnt_next = cnt_reg + 4'd1;
               if (cnt_reg == WAIT_LAST) begin
                  state_next = L2;
                  cnt_next   = '0;
               end
            end
         end
         L2: begin
            if (!stall) begin
               mac_en   = 1'b1;
               layer    = 1'b1;
               nrn_idx  = {1'b0, cnt_reg[2]};
               src_idx  = cnt_reg[1:0];
               mac_clr  = (cnt_reg[1:0] == 2'd0);
               cnt_next = cnt_reg + 4'd1;
               if (cnt_reg == 4'd7) begin
                  state_next = WAIT2;
                  cnt_next   = '0;
               end
            end
         end
         WAIT2: begin
            if (!stall) begin
               cnt_next = cnt_reg + 4'd1;
               if (cnt_reg == WAIT_LAST) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign busy    = (state_reg != IDLE);
   assign overrun = busy && in_ready && !rst;

   // A dot product completes when its last source term issues.
   assign dly_next   = {mac_en && (src_idx == 2'd3), layer, nrn_idx};
   assign dly_tail   = dly_reg[MAC_LAT-1];
   assign hid_wr     = dly_tail[3] && !dly_tail[2] && !stall;
   assign out_wr     = dly_tail[3] && dly_tail[2] && !stall;
   assign wr_idx     = (hid_wr || out_wr) ? dly_tail[1:0] : 2'd0;
   assign out0_ready = out_wr && (wr_idx == 2'd0);
   assign out1_ready = out_wr && (wr_idx == 2'd1);
endmodule

// File: tb/tb_dnn_mac_sched.sv
// Bench for dnn_mac_sched: MAC_LAT=1 and MAC_LAT=3 instances, scoreboard of write-back events
// plus a behavioural datapath that follows the sequencer and checks the computed values.
module tb_dnn_mac_sched;
   logic clk = 1'b0;
   logic rst, in_ready, stall;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       in_ack_s [2], busy_s [2], overrun_s [2], mac_en_s [2], mac_clr_s [2], layer_s [2];
   logic       hid_wr_s [2], out_wr_s [2], out0_s [2], out1_s [2];
   logic [1:0] nrn_s [2], src_s [2], wr_idx_s [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         dnn_mac_sched #(.MAC_LAT(gi == 0 ? 1 : 3)) dut (
            .clk(clk),
            .rst(rst),
            .in_ready(in_ready),
`ifdef DNN_SCHED_STALL_EN
            .mac_stall(gi == 0 ? stall : 1'b0),
`endif
            .in_ack(in_ack_s[gi]),
            .busy(busy_s[gi]),
            .overrun(overrun_s[gi]),
            .mac_en(mac_en_s[gi]),
            .mac_clr(mac_clr_s[gi]),
            .layer(layer_s[gi]),
            .nrn_idx(nrn_s[gi]),
            .src_idx(src_s[gi]),
            .hid_wr(hid_wr_s[gi]),
            .out_wr(out_wr_s[gi]),
            .wr_idx(wr_idx_s[gi]),
            .out0_ready(out0_s[gi]),
            .out1_ready(out1_s[gi])
         );
      end
   endgenerate

   typedef struct {
      int cyc;
      bit is_out;
      int idx;
      int val;
   } ev_t;

   ev_t exp_q0 [$];
   ev_t exp_q1 [$];

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;
   bit stall_test = 1'b0;
   int busy_from [2];
   int frame_end [2];
   int n_mac [2];
   int n_clr [2];
   bit in_frame [2];
   int px [4];
   int pw1 [16];
   int pw2 [8];
   int dx [2][4];
   int dw1 [2][16];
   int dw2 [2][8];
   int dhid [2][4];
   int dacc [2];
   int dpipe [2][4];

   task automatic check(input string tag, input int d, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", tag, d, cyc, act, exp);
      end
   endtask

   function automatic void push_ev(input int d, input ev_t e);
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endfunction

   function automatic int q_size(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic ev_t q_pop(input int d);
      if (d == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   function automatic int q_front_cyc(input int d);
      if (q_size(d) == 0) return -1;
      return (d == 0) ? exp_q0[0].cyc : exp_q1[0].cyc;
   endfunction

   function automatic void q_clear(input int d);
      if (d == 0) exp_q0.delete();
      else exp_q1.delete();
   endfunction

   function automatic int outs(input int d);
      return {16'd0, in_ack_s[d], busy_s[d], overrun_s[d], mac_en_s[d], mac_clr_s[d], layer_s[d],
              nrn_s[d], src_s[d], hid_wr_s[d], out_wr_s[d], wr_idx_s[d], out0_s[d], out1_s[d]};
   endfunction

   // Expected frame built from the presented operands at the accept cycle c.
   function automatic void accept(input int d, input int c);
      int  lat, sh;
      int  he [4];
      int  oe [2];
      ev_t e;
      lat = (d == 0) ? 1 : 3;
      sh  = (d == 0 && stall_test) ? 3 : 0;
      for (int n = 0; n < 4; n++) begin
         he[n] = 0;
         for (int s = 0; s < 4; s++) he[n] += px[s] * pw1[n*4+s];
      end
      for (int m = 0; m < 2; m++) begin
         oe[m] = 0;
         for (int s = 0; s < 4; s++) oe[m] += he[s] * pw2[m*4+s];
      end
      for (int n = 0; n < 4; n++) begin
         e.cyc = c + 4*n + 4 + lat + sh; e.is_out = 1'b0; e.idx = n; e.val = he[n];
         push_ev(d, e);
      end
      for (int m = 0; m < 2; m++) begin
         e.cyc = c + 20 + 2*lat + 4*m + sh; e.is_out = 1'b1; e.idx = m; e.val = oe[m];
         push_ev(d, e);
      end
      busy_from[d] = c + 1;
      frame_end[d] = c + 25 + 2*lat + sh;
      in_frame[d]  = 1'b1;
      n_mac[d]     = 0;
      n_clr[d]     = 0;
   endfunction

   task automatic monitor(input int d);
      int  lat, prod, ni, si;
      bit  exp_busy, stl, due;
      ev_t e;
      lat      = (d == 0) ? 1 : 3;
      stl      = (d == 0) && stall;
      exp_busy = (cyc >= busy_from[d]) && (cyc < frame_end[d]);
      check("busy", d, busy_s[d], exp_busy);
      check("in_ack", d, in_ack_s[d], in_ready && !exp_busy && !rst);
      check("overrun", d, overrun_s[d], in_ready && exp_busy && !rst);

      due = (q_front_cyc(d) == cyc);
      if (due || hid_wr_s[d] || out_wr_s[d]) begin
         if (q_size(d) == 0) begin
            check("unexp_wr", d, hid_wr_s[d] || out_wr_s[d], 0);
         end else begin
            e = q_pop(d);
            check("wr_cyc", d, cyc, e.cyc);
            check("hid_wr", d, hid_wr_s[d], !e.is_out);
            check("out_wr", d, out_wr_s[d], e.is_out);
            check("wr_idx", d, wr_idx_s[d], e.idx);
            check("out0_ready", d, out0_s[d], e.is_out && e.idx == 0);
            check("out1_ready", d, out1_s[d], e.is_out && e.idx == 1);
            check("wr_val", d, dpipe[d][lat-1], e.val);
            $display("dut%0d cyc=%0d %s[%0d] value=%0d", d, cyc, e.is_out ? "out" : "hid", e.idx,
                     dpipe[d][lat-1]);
         end
         if (hid_wr_s[d]) dhid[d][wr_idx_s[d]] = dpipe[d][lat-1];
      end else begin
         check("rdy_quiet", d, {out0_s[d], out1_s[d]}, 0);
      end

      if (in_ack_s[d]) begin
         for (int i = 0; i < 4; i++) dx[d][i] = px[i];
         for (int i = 0; i < 16; i++) dw1[d][i] = pw1[i];
         for (int i = 0; i < 8; i++) dw2[d][i] = pw2[i];
      end
      if (stl) check("stall_mac_en", d, mac_en_s[d], 0);
      if (mac_en_s[d]) begin
         n_mac[d]++;
         if (mac_clr_s[d]) n_clr[d]++;
         ni   = int'(nrn_s[d]);
         si   = int'(src_s[d]);
         prod = layer_s[d] ? dhid[d][si] * dw2[d][(ni*4+si) % 8] : dx[d][si] * dw1[d][ni*4+si];
         dacc[d] = mac_clr_s[d] ? prod : dacc[d] + prod;
      end else begin
         check("idle_idx", d, {mac_clr_s[d], layer_s[d], nrn_s[d], src_s[d]}, 0);
      end
      if (!stl) begin
         for (int k = 3; k > 0; k--) dpipe[d][k] = dpipe[d][k-1];
         dpipe[d][0] = dacc[d];
      end

      if (in_frame[d] && cyc == frame_end[d]) begin
         in_frame[d] = 1'b0;
         check("n_mac", d, n_mac[d], 24);
         check("n_clr", d, n_clr[d], 6);
         check("q_empty", d, q_size(d), 0);
      end
      if (rst) begin
         q_clear(d);
         in_frame[d]  = 1'b0;
         frame_end[d] = cyc + 1;
      end else if (in_ready && !exp_busy) begin
         $display("dut%0d cyc=%0d accept", d, cyc);
         accept(d, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         monitor(0);
         monitor(1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) tick();
   endtask

   task automatic set_ref();
      px = '{1, -2, 3, -4};
      for (int i = 0; i < 16; i++) pw1[i] = 1;
      for (int i = 0; i < 8; i++) pw2[i] = 1;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 4; i++) px[i] = int'($urandom_range(31)) - 16;
      for (int i = 0; i < 16; i++) pw1[i] = int'($urandom_range(31)) - 16;
      for (int i = 0; i < 8; i++) pw2[i] = int'($urandom_range(31)) - 16;
   endtask

   task automatic pulse_at(input int c);
      goto_cyc(c);
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && (busy_s[0] || busy_s[1]); i++) tick();
      check("idle_timeout", 0, busy_s[0] || busy_s[1], 0);
      tick();
      tick();
   endtask

   initial begin
      int a;
      rst      = 1'b1;
      in_ready = 1'b0;
      stall    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         busy_from[d] = 0; frame_end[d] = 0; in_frame[d] = 1'b0; dacc[d] = 0;
         for (int k = 0; k < 4; k++) begin dpipe[d][k] = 0; dhid[d][k] = 0; end
      end
      set_ref();
      repeat (3) tick();
      rst    = 1'b0;
      mon_en = 1'b1;
      check("rst_outs", 0, outs(0), 0);
      check("rst_outs", 1, outs(1), 0);

      // Reference frame with overrun pulses during L1 and L2.
      tick();
      a = cyc;
      pulse_at(a);
      pulse_at(a + 3);
      pulse_at(a + 20);
      wait_idle();

      repeat (3) begin
         set_rand();
         tick();
         pulse_at(cyc);
         wait_idle();
      end

      // in_ready held high: back-to-back frames, operands changing every cycle.
      set_rand();
      in_ready = 1'b1;
      repeat (70) begin
         tick();
         set_rand();
      end
      in_ready = 1'b0;
      wait_idle();

      // Reset in the middle of L1.
      set_rand();
      tick();
      a = cyc;
      pulse_at(a);
      goto_cyc(a + 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_outs", 0, outs(0), 0);
      check("rst_mid_outs", 1, outs(1), 0);
      repeat (10) tick();
      set_ref();
      pulse_at(cyc);
      wait_idle();

`ifdef DNN_SCHED_STALL_EN
      stall_test = 1'b1;
      tick();
      a = cyc;
      pulse_at(a);
      goto_cyc(a + 5);
      stall = 1'b1;
      goto_cyc(a + 8);
      stall = 1'b0;
      wait_idle();
      stall_test = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "timeout");
   end
endmodule
